// File: rtl/hs_npu_replay_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hs_npu_replay_pkg : state type and count-width helper for the replay sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package hs_npu_replay_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_LOAD   = 3'd2,
    S_PASS   = 3'd3,
    S_REREAD = 3'd4,
    S_FIN    = 3'd5,
    S_DONE   = 3'd6
  } replay_state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_npu_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hs_npu_fifo : circular FIFO (DEPTH-1 usable) with flush and reread-from-base
// Rev 1.0
// ---------------------------------------------------------------------------
module hs_npu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             reread_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;

  // Flush rewinds both pointers to slot 0, so reread can always restart from 0.
  assign ready_o = (wr_q + AW'(1)) != rd_q;
  assign valid_o = wr_q != rd_q;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (valid_i && ready_o) wr_q <= wr_q + AW'(1);
      if (reread_i)                rd_q <= '0;
      else if (valid_o && ready_i) rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (valid_i && ready_o && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/hs_npu_fifo_replay_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hs_npu_fifo_replay_ctrl : flush/load/replay sequencer around one hs_npu_fifo.
// Optional abort port set enabled by HS_NPU_REPLAY_ABORT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module hs_npu_fifo_replay_ctrl
  import hs_npu_replay_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_BITS = 8
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
`ifdef HS_NPU_REPLAY_ABORT_EN
  input  logic                     abort_i,
  output logic                     aborted_o,
`endif
  input  logic                     start_i,
  input  logic [$clog2(DEPTH)-1:0] load_len_i,
  input  logic [CNT_BITS-1:0]      repeat_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic                     src_valid_i,
  output logic                     src_ready_o,
  input  logic [WIDTH-1:0]         src_data_i,
  output logic                     fifo_flush_o,
  output logic                     fifo_reread_o,
  output logic                     fifo_valid_o,
  output logic [WIDTH-1:0]         fifo_data_o,
  input  logic                     fifo_ready_i,
  input  logic                     fifo_valid_i,
  input  logic [WIDTH-1:0]         fifo_data_i,
  output logic                     fifo_ready_o,
  output logic                     dst_valid_o,
  output logic [WIDTH-1:0]         dst_data_o,
  output logic                     dst_last_o,
  input  logic                     dst_ready_i
);

  localparam int LW = cnt_width(DEPTH);

  replay_state_t       state_q, state_d;
  logic [LW-1:0]       load_len_q, load_len_d;
  logic [CNT_BITS-1:0] repeat_q, repeat_d;
  logic [LW-1:0]       word_cnt_q, word_cnt_d;
  logic [CNT_BITS-1:0] pass_cnt_q, pass_cnt_d;
  logic                last_word;
  logic                abort_hit;

`ifdef HS_NPU_REPLAY_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit = abort_i && (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_DONE);
  assign aborted_o = (state_q == S_DONE) && aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  assign fifo_data_o = src_data_i;
  assign dst_data_o  = fifo_data_i;
  assign last_word   = (word_cnt_q == load_len_q - LW'(1));

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q    <= S_IDLE;
      load_len_q <= '0;
      repeat_q   <= '0;
      word_cnt_q <= '0;
      pass_cnt_q <= '0;
`ifdef HS_NPU_REPLAY_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      load_len_q <= load_len_d;
      repeat_q   <= repeat_d;
      word_cnt_q <= word_cnt_d;
      pass_cnt_q <= pass_cnt_d;
`ifdef HS_NPU_REPLAY_ABORT_EN
      aborted_q  <= aborted_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    load_len_d    = load_len_q;
    repeat_d      = repeat_q;
    word_cnt_d    = word_cnt_q;
    pass_cnt_d    = pass_cnt_q;
    busy_o        = (state_q != S_IDLE);
    done_o        = 1'b0;
    fifo_flush_o  = 1'b0;
    fifo_reread_o = 1'b0;
    src_ready_o   = 1'b0;
    fifo_valid_o  = 1'b0;
    fifo_ready_o  = 1'b0;
    dst_valid_o   = 1'b0;
    dst_last_o    = 1'b0;
`ifdef HS_NPU_REPLAY_ABORT_EN
    aborted_d     = aborted_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load_len_d = load_len_i;
          repeat_d   = repeat_i;
          word_cnt_d = '0;
          pass_cnt_d = '0;
          state_d    = S_FLUSH;
`ifdef HS_NPU_REPLAY_ABORT_EN
          aborted_d  = 1'b0;
`endif
        end
      end
      S_FLUSH: begin
        fifo_flush_o = 1'b1;
        word_cnt_d   = '0;
        state_d      = ((load_len_q != '0) && (repeat_q != '0)) ? S_LOAD : S_FIN;
      end
      S_LOAD: begin
        // The FIFO read side stays stalled; the block is only written here.
        if (word_cnt_q == load_len_q) begin
          word_cnt_d = '0;
          state_d    = S_PASS;
        end else begin
          fifo_valid_o = src_valid_i;
          src_ready_o  = fifo_ready_i;
          if (src_valid_i && fifo_ready_i) word_cnt_d = word_cnt_q + LW'(1);
        end
      end
      S_PASS: begin
        dst_valid_o  = fifo_valid_i;
        fifo_ready_o = dst_ready_i;
        dst_last_o   = fifo_valid_i && last_word;
        if (fifo_valid_i && dst_ready_i) begin
          if (last_word) begin
            pass_cnt_d = pass_cnt_q + CNT_BITS'(1);
            state_d    = ((pass_cnt_q + CNT_BITS'(1)) == repeat_q) ? S_FIN : S_REREAD;
          end else begin
            word_cnt_d = word_cnt_q + LW'(1);
          end
        end
      end
      S_REREAD: begin
        fifo_reread_o = 1'b1;
        word_cnt_d    = '0;
        state_d       = S_PASS;
      end
      S_FIN: begin
        fifo_flush_o = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d      = S_FIN;
      src_ready_o  = 1'b0;
      fifo_valid_o = 1'b0;
      fifo_ready_o = 1'b0;
      dst_valid_o  = 1'b0;
      dst_last_o   = 1'b0;
`ifdef HS_NPU_REPLAY_ABORT_EN
      aborted_d    = 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire
